// File: rtl/chroma_pkg.sv
// Shared types and helpers for the chroma upsampler.
// Beats per block come from the latched sampling mode through nbeats().
package chroma_pkg;

  // Largest channel tag value; sets the default channel tag width.
  localparam int unsigned CH_MAX = 2;

  typedef enum logic [1:0] {
    MODE_444  = 2'b00,
    MODE_422  = 2'b01,
    MODE_420  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    CH_NONE = 2'd0,
    CH_CB   = 2'd1,
    CH_CR   = 2'd2
  } ch_e;

  typedef enum logic {
    StIdle = 1'b0,
    StEmit = 1'b1
  } state_e;

  // Output beats produced per source block; the reserved mode behaves as 4:4:4.
  function automatic logic [2:0] nbeats(mode_e mode);
    logic [2:0] n;
    case (mode)
      MODE_422: n = 3'd2;
      MODE_420: n = 3'd4;
      default:  n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/upsample_map.sv
// Combinational sample replication: selects the source quadrant/half for the
// current beat and doubles each source sample horizontally (and vertically for 4:2:0).
module upsample_map
  import chroma_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned BLK   = 8
) (
  input  logic [BLK-1:0][BLK-1:0][PIX_W-1:0] i_block,
  input  mode_e                              i_mode,
  input  logic [1:0]                         i_idx,
  output logic [BLK-1:0][BLK-1:0][PIX_W-1:0] o_block
);

  localparam int unsigned H = BLK / 2;

  for (genvar r = 0; r < BLK; r++) begin : g_row
    for (genvar c = 0; c < BLK; c++) begin : g_col
      localparam int unsigned R2 = r / 2;
      localparam int unsigned C2 = c / 2;

      logic [PIX_W-1:0] w_pix;

      // Per-output-sample source select; all indices are elaboration constants.
      always_comb begin
        w_pix = i_block[r][c];
        case (i_mode)
          MODE_422: w_pix = i_idx[0] ? i_block[r][C2 + H] : i_block[r][C2];
          MODE_420: begin
            case (i_idx)
              2'd0:    w_pix = i_block[R2][C2];
              2'd1:    w_pix = i_block[R2][C2 + H];
              2'd2:    w_pix = i_block[R2 + H][C2];
              default: w_pix = i_block[R2 + H][C2 + H];
            endcase
          end
          default:  w_pix = i_block[r][c];
        endcase
      end

      assign o_block[r][c] = w_pix;
    end
  end

endmodule

// File: rtl/chroma_upsample_stream.sv
// Streaming chroma upsampler: accepts one subsampled Cb/Cr block per handshake
// and emits 1, 2 or 4 full-resolution blocks, one per output beat.
// Define CHROMA_UPSAMPLE_SKID_EN to add a second (skid) buffer so a following
// block can be accepted while the current one is emitted (no idle bubble).
module chroma_upsample_stream
  import chroma_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned BLK   = 8,
  parameter int unsigned CH_W  = $clog2(CH_MAX + 1)
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              valid_in,
  output logic                              ready_in,
  input  logic [1:0]                        mode_in,
  input  logic [CH_W-1:0]                   ch_in,
  input  logic [BLK-1:0][BLK-1:0][PIX_W-1:0] block_in,
  output logic                              valid_out,
  input  logic                              ready_out,
  output logic [BLK-1:0][BLK-1:0][PIX_W-1:0] block_out,
  output logic [1:0]                        blk_idx,
  output logic [CH_W-1:0]                   ch_out,
  output logic                              last_out
);

  typedef logic [BLK-1:0][BLK-1:0][PIX_W-1:0] blk_t;

  state_e          r_state;
  state_e          w_state_next;
  blk_t            r_buf;
  mode_e           r_mode;
  logic [CH_W-1:0] r_ch;
  logic [1:0]      r_idx;

  logic [1:0]      w_last_idx;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_fire_last;
  logic            w_load_in;
  logic            w_reload_skid;

`ifdef CHROMA_UPSAMPLE_SKID_EN
  blk_t            r_skid_buf;
  mode_e           r_skid_mode;
  logic [CH_W-1:0] r_skid_ch;
  logic            r_skid_full;
  logic            w_skid_wr;
`endif

  assign w_last_idx  = 2'(nbeats(r_mode) - 3'd1);
  assign w_in_fire   = valid_in && ready_in;
  assign w_out_fire  = valid_out && ready_out;
  assign w_fire_last = w_out_fire && (r_idx == w_last_idx);

`ifdef CHROMA_UPSAMPLE_SKID_EN
  assign w_reload_skid = w_fire_last && r_skid_full;
  // A block arriving on the final-beat handshake with an empty skid goes straight
  // into the main buffer; otherwise a block accepted during EMIT waits in skid.
  assign w_load_in     = w_in_fire && ((r_state == StIdle) || (w_fire_last && !r_skid_full));
  assign w_skid_wr     = w_in_fire && !w_load_in;
`else
  assign w_reload_skid = 1'b0;
  // ready_in is only high in IDLE, so every accept loads the main buffer.
  assign w_load_in     = w_in_fire;
`endif

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: leave EMIT after the final beat unless another block is ready.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_load_in) w_state_next = StEmit;
      end
      StEmit: begin
        if (w_fire_last && !w_load_in && !w_reload_skid) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: everything registered-derived, no ready_out -> ready_in path.
  always_comb begin
    valid_out = (r_state == StEmit);
`ifdef CHROMA_UPSAMPLE_SKID_EN
    ready_in  = !r_skid_full;
`else
    ready_in  = (r_state == StIdle);
`endif
    last_out  = valid_out && (r_idx == w_last_idx);
    blk_idx   = r_idx;
    ch_out    = r_ch;
  end

  // Main buffer: loaded from the input port or from the skid buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_buf  <= '0;
      r_mode <= MODE_444;
      r_ch   <= '0;
    end else if (w_load_in) begin
      r_buf  <= block_in;
      r_mode <= mode_e'(mode_in);
      r_ch   <= ch_in;
`ifdef CHROMA_UPSAMPLE_SKID_EN
    end else if (w_reload_skid) begin
      r_buf  <= r_skid_buf;
      r_mode <= r_skid_mode;
      r_ch   <= r_skid_ch;
`endif
    end
  end

  // Beat index: restarts on every new block, advances on each non-final handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= 2'd0;
    end else if (w_load_in || w_reload_skid || w_fire_last) begin
      r_idx <= 2'd0;
    end else if (w_out_fire) begin
      r_idx <= r_idx + 2'd1;
    end
  end

`ifdef CHROMA_UPSAMPLE_SKID_EN
  // Skid buffer: a write wins over a simultaneous drain so the new block is kept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_skid_buf  <= '0;
      r_skid_mode <= MODE_444;
      r_skid_ch   <= '0;
      r_skid_full <= 1'b0;
    end else if (w_skid_wr) begin
      r_skid_buf  <= block_in;
      r_skid_mode <= mode_e'(mode_in);
      r_skid_ch   <= ch_in;
      r_skid_full <= 1'b1;
    end else if (w_reload_skid) begin
      r_skid_full <= 1'b0;
    end
  end
`endif

  upsample_map #(
    .PIX_W (PIX_W),
    .BLK   (BLK)
  ) u_map (
    .i_block (r_buf),
    .i_mode  (r_mode),
    .i_idx   (r_idx),
    .o_block (block_out)
  );

endmodule
